sie_rx: RTL
===========

Name: sie_rx

Overview:
Receive-side packet decoder of the SIE. It sits directly downstream of the full-speed receiver PHY and consumes its byte/error/EOP strobe stream. It checks PIDs and CRC5/CRC16, extracts token fields, and strips the trailing CRC16 from data payloads. It emits per-packet events to the endpoint/control logic.

Parameters:
MAX_PKT, 64, maximum data payload bytes accepted (CRC16 excluded); must be ≥ 1.

Ports:
clk_i  in  1  12MHz*BIT_SAMPLES clock, same as PHY.
rstn_i  in  1  asynchronous active-low reset.
rx_data_i  in  8  PHY byte, LSB first on the wire.
rx_valid_i  in  1  PHY byte-in-progress flag.
rx_err_i  in  1  PHY error flag.
rx_ready_i  in  1  PHY one-cycle strobe. Meaning by flag state: valid=1 → byte; err=1 → abort; both 0 → EOP.
usb_reset_i  in  1  bus reset from PHY.
pid_o  out  4  PID[3:0] of the last accepted packet.
addr_o  out  7  token address.
endp_o  out  4  token endpoint.
frame_o  out  11  SOF frame number.
token_o  out  1  one-cycle pulse: valid OUT/IN/SETUP/SOF token received.
hsk_o  out  1  one-cycle pulse: valid ACK/NAK/STALL received.
data_o  out  8  payload byte.
data_valid_o  out  1  one-cycle pulse: data_o is a payload byte.
data_end_o  out  1  one-cycle pulse at the end of any DATA0/DATA1 packet, whether OK or aborted.
data_ok_o  out  1  qualifies data_end_o: CRC16 residual correct and length within range.
rx_err_o  out  1  one-cycle pulse: packet dropped (PID, CRC, length, or PHY error).

Behaviour:
- Reset (async or usb_reset_i high): state ST_IDLE; all outputs 0; held fields pid/addr/endp/frame cleared.
- usb_reset_i is synchronous and dominates any simultaneous rx_ready_i.
- Bytes are accepted only on cycles with rx_ready_i=1. All outputs are registered, with latency 1 clk after the rx_ready_i strobe.
- First byte is the PID. The PID is valid only if byte[7:4] == ~byte[3:0].
  - Token PIDs: OUT=0001, IN=1001, SOF=0101, SETUP=1101.
  - Data PIDs: DATA0=0011, DATA1=1011.
  - Handshake PIDs: ACK=0010, NAK=1010, STALL=1110.
  - Any other PID, or a failed PID check → ST_DRAIN.
- States: ST_IDLE, ST_TOKEN, ST_DATA, ST_HSK, ST_DRAIN.
  - ST_TOKEN: collect exactly 2 bytes and run CRC5 over those 11+5 bits.
    - EOP after 2 bytes with CRC5 residual 5'b01100 → token_o pulse.
      - Non-SOF: addr_o = b1[6:0], endp_o = {b2[2:0], b1[7]}.
      - SOF: frame_o = {b2[2:0], b1}.
    - Wrong count or bad CRC → rx_err_o, fields unchanged.
    - A third byte → ST_DRAIN.
  - ST_DATA: CRC16 runs over all bytes after the PID (poly x^16+x^15+x^2+1, init 16'hFFFF, LSB-first).
    - A 2-byte delay line holds bytes. Byte n is emitted (data_valid_o) when byte n+2 arrives, so the two CRC bytes are never emitted.
    - EOP: data_end_o pulses. data_ok_o=1 iff ≥2 bytes were received after the PID, residual == 16'h800D, and no overflow.
    - Zero-length payload (PID+2 CRC bytes) is legal.
    - If the payload exceeds MAX_PKT bytes, set an overflow flag and stop emitting bytes. The packet still completes with data_ok_o=0.
  - ST_HSK: EOP immediately after the PID → hsk_o. Any extra byte → ST_DRAIN.
  - ST_DRAIN: ignore bytes; at EOP pulse rx_err_o.
- Exit rules:
  - Every EOP returns the FSM to ST_IDLE.
  - PHY abort (rx_ready_i & rx_err_i) in any non-idle state → rx_err_o pulse, ST_IDLE. In ST_DATA it also pulses data_end_o with data_ok_o=0.
  - EOP or abort in ST_IDLE (no PID yet) → rx_err_o only.
- pid_o updates only with token_o, hsk_o, or data_end_o with data_ok_o=1.
- Byte counter width is ceil_log2(MAX_PKT+3). The counter saturates and never wraps.

Decomposition:
- Package usb_pkg holds:
  - PID localparams;
  - CRC5 poly 5'h05, init 5'h1F, residual 5'h0C;
  - CRC16 poly 16'h8005, init 16'hFFFF, residual 16'h800D.
- Sub-module usb_crc_byte: combinational byte-wise CRC5/CRC16 update, selected by a mode input. Shared later with sie_tx.

Test Plan:
- SETUP token: bytes 2D,00,10 then EOP → token_o=1 for one cycle, pid_o=D, addr_o=0, endp_o=0; rx_err_o stays 0.
- DATA0 setup payload: bytes C3,80,06,00,01,00,00,40,00,DD,94 then EOP → 8 data_valid_o pulses carrying 80 06 00 01 00 00 40 00, then data_end_o=1 with data_ok_o=1.
- Zero-length DATA1: 4B,00,00, EOP → no data_valid_o, data_end_o=1, data_ok_o=1. The same packet with CRC byte 01 → data_ok_o=0.
- ACK: D2 then EOP → hsk_o=1, pid_o=2. A token with a corrupted CRC (2D,00,11) → rx_err_o=1, no token_o, addr/endp unchanged.
- Bad PID 2C,xx,EOP → rx_err_o at EOP only. DATA0 with MAX_PKT+1 payload bytes → exactly MAX_PKT pulses, then data_end_o with data_ok_o=0.
- usb_reset_i asserted mid-DATA0 after 3 bytes → next cycle all outputs 0 and ST_IDLE. A following 2D,00,10 decodes normally.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB SIE definitions: PID codes, CRC constants and receive-path types.
package usb_pkg;

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidSof   = 4'b0101;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;

    localparam logic [4:0]  Crc5Poly      = 5'h05;
    localparam logic [4:0]  Crc5Init      = 5'h1F;
    localparam logic [4:0]  Crc5Residual  = 5'h0C;
    localparam logic [15:0] Crc16Poly     = 16'h8005;
    localparam logic [15:0] Crc16Init     = 16'hFFFF;
    localparam logic [15:0] Crc16Residual = 16'h800D;

    typedef enum logic {CrcMode5, CrcMode16} crc_mode_e;

    typedef enum logic [2:0] {StIdle, StToken, StData, StHsk, StDrain} rx_state_e;

    typedef struct packed {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [10:0] frame;
        logic        token;
        logic        hsk;
        logic [7:0]  data;
        logic        data_valid;
        logic        data_end;
        logic        data_ok;
        logic        err;
    } rx_out_t;

endpackage

// File: rtl/sie_rx_if.sv
// PHY receive stream into the decoder and the per-packet events it produces.
interface sie_rx_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic        rx_ready;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
    logic        token;
    logic        hsk;
    logic [7:0]  data;
    logic        data_valid;
    logic        data_end;
    logic        data_ok;
    logic        pkt_err;

    modport master (
        output rx_data, rx_valid, rx_err, rx_ready,
        input  pid, addr, endp, frame, token, hsk, data, data_valid, data_end, data_ok, pkt_err
    );

    modport slave (
        input  rx_data, rx_valid, rx_err, rx_ready,
        output pid, addr, endp, frame, token, hsk, data, data_valid, data_end, data_ok, pkt_err
    );
endinterface

// File: rtl/usb_crc_byte.sv
// Byte-wise CRC5/CRC16 update, data bits consumed LSB first; CRC5 lives in crc_o[4:0].
module usb_crc_byte
    import usb_pkg::*;
(
    input  crc_mode_e   mode_i,
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (mode_i == CrcMode5) begin
                crc_o = {11'h0, crc_o[3:0], 1'b0} ^
                        ((crc_o[4] ^ data_i[i]) ? {11'h0, Crc5Poly} : 16'h0);
            end else begin
                crc_o = {crc_o[14:0], 1'b0} ^ ((crc_o[15] ^ data_i[i]) ? Crc16Poly : 16'h0);
            end
        end
    end

endmodule

// File: rtl/sie_rx.sv
// SIE receive decoder: PID/CRC checking, token field extraction and data payload
// delivery with the trailing CRC16 stripped.
module sie_rx
    import usb_pkg::*;
#(
    parameter int unsigned MAX_PKT = 64
) (
    input logic     clk_i,
    input logic     rstn_i,
    input logic     usb_reset_i,
    sie_rx_if.slave rx
);

    localparam int unsigned CntW = $clog2(MAX_PKT + 3);

    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     crc_q, crc_d, crc_next;
    logic [7:0]      dly0_q, dly0_d, dly1_q, dly1_d;
    logic [3:0]      cur_pid_q, cur_pid_d;
    logic            ovf_q, ovf_d;
    rx_out_t         out_q, out_d;
    crc_mode_e       crc_mode;
    logic            is_byte, is_eop, is_abort;

    assign is_byte  = rx.rx_ready & rx.rx_valid & ~rx.rx_err;
    assign is_eop   = rx.rx_ready & ~rx.rx_valid & ~rx.rx_err;
    assign is_abort = rx.rx_ready & rx.rx_err;
    assign crc_mode = (state_q == StToken) ? CrcMode5 : CrcMode16;

    usb_crc_byte u_crc (
        .mode_i (crc_mode),
        .crc_i  (crc_q),
        .data_i (rx.rx_data),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        crc_d          = crc_q;
        dly0_d         = dly0_q;
        dly1_d         = dly1_q;
        cur_pid_d      = cur_pid_q;
        ovf_d          = ovf_q;
        out_d          = out_q;
        out_d.token    = 1'b0;
        out_d.hsk      = 1'b0;
        out_d.data_valid = 1'b0;
        out_d.data_end = 1'b0;
        out_d.data_ok  = 1'b0;
        out_d.err      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_byte) begin
                    cur_pid_d = rx.rx_data[3:0];
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    crc_d     = Crc16Init;
                    if (rx.rx_data[7:4] != ~rx.rx_data[3:0]) begin
                        state_d = StDrain;
                    end else begin
                        case (rx.rx_data[3:0])
                            PidOut, PidIn, PidSof, PidSetup: begin
                                state_d = StToken;
                                crc_d   = {11'h0, Crc5Init};
                            end
                            PidData0, PidData1:       state_d = StData;
                            PidAck, PidNak, PidStall: state_d = StHsk;
                            default:                  state_d = StDrain;
                        endcase
                    end
                end else if (is_eop) begin
                    out_d.err = 1'b1;
                end
            end
            StToken: begin
                if (is_byte) begin
                    if (cnt_q == CntW'(2)) begin
                        state_d = StDrain;
                    end else begin
                        cnt_d  = cnt_q + CntW'(1);
                        crc_d  = crc_next;
                        dly1_d = dly0_q;
                        dly0_d = rx.rx_data;
                    end
                end else if (is_eop) begin
                    state_d = StIdle;
                    if (cnt_q == CntW'(2) && crc_q[4:0] == Crc5Residual) begin
                        out_d.token = 1'b1;
                        out_d.pid   = cur_pid_q;
                        // dly1 holds the first token byte, dly0 the second
                        if (cur_pid_q == PidSof) begin
                            out_d.frame = {dly0_q[2:0], dly1_q};
                        end else begin
                            out_d.addr = dly1_q[6:0];
                            out_d.endp = {dly0_q[2:0], dly1_q[7]};
                        end
                    end else begin
                        out_d.err = 1'b1;
                    end
                end
            end
            StData: begin
                if (is_byte) begin
                    crc_d  = crc_next;
                    dly1_d = dly0_q;
                    dly0_d = rx.rx_data;
                    if (cnt_q != '1) cnt_d = cnt_q + CntW'(1);
                    // Emitting byte n as byte n+2 arrives keeps the CRC16 pair out of the stream
                    if (cnt_q >= CntW'(MAX_PKT + 2)) begin
                        ovf_d = 1'b1;
                    end else if (cnt_q >= CntW'(2)) begin
                        out_d.data       = dly1_q;
                        out_d.data_valid = 1'b1;
                    end
                end else if (is_eop) begin
                    state_d        = StIdle;
                    out_d.data_end = 1'b1;
                    if (cnt_q >= CntW'(2) && crc_q == Crc16Residual && !ovf_q) begin
                        out_d.data_ok = 1'b1;
                        out_d.pid     = cur_pid_q;
                    end else begin
                        out_d.err = 1'b1;
                    end
                end
            end
            StHsk: begin
                if (is_byte) begin
                    state_d = StDrain;
                end else if (is_eop) begin
                    state_d   = StIdle;
                    out_d.hsk = 1'b1;
                    out_d.pid = cur_pid_q;
                end
            end
            StDrain: begin
                if (is_eop) begin
                    state_d   = StIdle;
                    out_d.err = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (is_abort) begin
            state_d        = StIdle;
            out_d.err      = 1'b1;
            out_d.data_end = (state_q == StData);
            out_d.data_ok  = 1'b0;
        end

        // Bus reset wins over anything the PHY strobed this cycle
        if (usb_reset_i) begin
            state_d   = StIdle;
            cnt_d     = '0;
            crc_d     = '0;
            dly0_d    = '0;
            dly1_d    = '0;
            cur_pid_d = '0;
            ovf_d     = 1'b0;
            out_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            crc_q     <= '0;
            dly0_q    <= '0;
            dly1_q    <= '0;
            cur_pid_q <= '0;
            ovf_q     <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            dly0_q    <= dly0_d;
            dly1_q    <= dly1_d;
            cur_pid_q <= cur_pid_d;
            ovf_q     <= ovf_d;
            out_q     <= out_d;
        end
    end

    assign rx.pid        = out_q.pid;
    assign rx.addr       = out_q.addr;
    assign rx.endp       = out_q.endp;
    assign rx.frame      = out_q.frame;
    assign rx.token      = out_q.token;
    assign rx.hsk        = out_q.hsk;
    assign rx.data       = out_q.data;
    assign rx.data_valid = out_q.data_valid;
    assign rx.data_end   = out_q.data_end;
    assign rx.data_ok    = out_q.data_ok;
    assign rx.pkt_err    = out_q.err;

endmodule
